// File: rtl/seg7_pkg.sv
// ---------------------------------------------------------------------------
// seg7_pkg
//   Shared definitions for the seven-segment LFSR self-check path.
//   - GLYPH_TABLE : active-low glyph for each hex nibble, indexed by nibble.
//                   Bit layout is {a,b,c,d,e,f,g,dp}; 0 means the segment is lit.
//   - DP_OFF      : required state of the decimal-point bit in a legal glyph.
//   - lfsr8_next  : one step of the 8-bit display LFSR.
//   - fsm_state_t : tracking state machine states.
// ---------------------------------------------------------------------------
package seg7_pkg;

    localparam logic DP_OFF = 1'b1;

    // Element [0] is the glyph for nibble 0, element [15] for nibble F.
    localparam logic [15:0][7:0] GLYPH_TABLE = {
        8'h71, 8'h61, 8'h85, 8'h63,   // F E d C
        8'hC1, 8'h11, 8'h09, 8'h01,   // b A 9 8
        8'h1F, 8'h41, 8'h49, 8'h99,   // 7 6 5 4
        8'h0D, 8'h25, 8'h9F, 8'h03    // 3 2 1 0
    };

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        LOCKED
    } fsm_state_t;

    // Shift right, XOR feedback of taps 4,3,2,0 enters at bit 7.
    function automatic logic [7:0] lfsr8_next(input logic [7:0] v);
        return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
    endfunction

endpackage

// File: rtl/seg7_glyph_dec.sv
// ---------------------------------------------------------------------------
// seg7_glyph_dec
//   Reverse-maps one active-low seven-segment glyph byte back to its hex nibble.
//   Ports:
//     glyph   in  8  glyph byte {a..g, dp}, active-low
//     nibble  out 4  decoded nibble (0 when the glyph is not legal)
//     legal   out 1  glyph is one of the 16 hex glyphs with dp unlit
// ---------------------------------------------------------------------------
module seg7_glyph_dec
    import seg7_pkg::*;
(
    input  logic [7:0] glyph,
    output logic [3:0] nibble,
    output logic       legal
);

    // Search the glyph table; the entries are distinct, so at most one hits.
    // The dp bit is checked explicitly so a lit dp can never pass as legal.
    always_comb begin
        nibble = 4'h0;
        legal  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (glyph == GLYPH_TABLE[i]) begin
                nibble = 4'(i);
                legal  = (glyph[0] == DP_OFF);
            end
        end
    end

endmodule

// File: rtl/seg_lfsr_checker.sv
// ---------------------------------------------------------------------------
// seg_lfsr_checker
//   Receive-side monitor for the LFSR-driven dual seven-segment display bus.
//   Captures the segment bus, decodes both glyphs to an 8-bit value and checks
//   that successive samples follow the 8-bit LFSR sequence.
//   Ports:
//     clk          in  1      rising-edge clock
//     rst          in  1      synchronous active-high reset
//     segment_dis  in  16     [15:8] high-nibble glyph, [7:0] low-nibble glyph
//     sample_en    in  1      capture segment_dis this cycle
//     value        out 8      decoded value {hi,lo}; 0 after an illegal sample
//     value_valid  out 1      pulse: value holds a legally decoded sample
//     locked       out 1      sequence tracked for LOCK_CNT consecutive steps
//     seq_err      out 1      pulse: sequence mismatch while locked
//     glyph_err    out 1      pulse: a sampled byte was not a legal glyph
//     err_cnt      out ERR_W  saturating count of seq_err + glyph_err events
//   Latency: value/value_valid/glyph_err two cycles after sample_en,
//   locked/seq_err/err_cnt one cycle after that.
// ---------------------------------------------------------------------------
module seg_lfsr_checker
    import seg7_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int ERR_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      segment_dis,
    input  logic             sample_en,
    output logic [7:0]       value,
    output logic             value_valid,
    output logic             locked,
    output logic             seq_err,
    output logic             glyph_err,
    output logic [ERR_W-1:0] err_cnt
);

    logic        s1_valid;
    logic [15:0] s1_seg;
    logic        s2_valid;

    logic [3:0]  hi_nib;
    logic [3:0]  lo_nib;
    logic        hi_legal;
    logic        lo_legal;
    logic        both_legal;

    fsm_state_t  state_q;
    fsm_state_t  state_d;
    logic [3:0]  run_q;
    logic [3:0]  run_d;
    logic [3:0]  run_inc;
    logic [7:0]  expect_q;
    logic [7:0]  expect_d;
    logic [7:0]  value_next;
    logic        seq_err_d;
    logic        err_inc;

    // Stage 1: capture the raw bus; reset discards any sample in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_seg   <= 16'h0000;
        end else begin
            s1_valid <= sample_en;
            if (sample_en) begin
                s1_seg <= segment_dis;
            end
        end
    end

    seg7_glyph_dec u_dec_hi (
        .glyph  (s1_seg[15:8]),
        .nibble (hi_nib),
        .legal  (hi_legal)
    );

    seg7_glyph_dec u_dec_lo (
        .glyph  (s1_seg[7:0]),
        .nibble (lo_nib),
        .legal  (lo_legal)
    );

    assign both_legal = hi_legal && lo_legal;

    // Stage 2: register the decoded value. value is held between samples and
    // forced to 0 for an illegal sample; s2_valid marks any sample (legal or
    // not) so the FSM reacts to glyph errors as well as good values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid    <= 1'b0;
            value       <= 8'h00;
            value_valid <= 1'b0;
            glyph_err   <= 1'b0;
        end else begin
            s2_valid    <= s1_valid;
            value_valid <= s1_valid && both_legal;
            glyph_err   <= s1_valid && !both_legal;
            if (s1_valid) begin
                value <= both_legal ? {hi_nib, lo_nib} : 8'h00;
            end
        end
    end

    // Tracking FSM state, run counter, expected value, error pulse and the
    // saturating error counter all update on the cycle after stage 2.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            run_q    <= 4'd0;
            expect_q <= 8'h00;
            seq_err  <= 1'b0;
            err_cnt  <= '0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            expect_q <= expect_d;
            seq_err  <= seq_err_d;
            if (err_inc && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    assign value_next = lfsr8_next(value);
    assign run_inc    = run_q + 4'd1;

    // Next-state logic. A glyph error overrides everything, so seq_err and
    // glyph_err can never fire for the same sample. Every legal sample reseeds
    // the expectation from itself, whether it matched or not.
    always_comb begin
        state_d   = state_q;
        run_d     = run_q;
        expect_d  = expect_q;
        seq_err_d = 1'b0;
        err_inc   = 1'b0;
        if (s2_valid) begin
            if (glyph_err) begin
                state_d = IDLE;
                run_d   = 4'd0;
                err_inc = 1'b1;
            end else begin
                expect_d = value_next;
                case (state_q)
                    IDLE: begin
                        run_d   = 4'd0;
                        state_d = TRACK;
                    end
                    TRACK: begin
                        if (value == expect_q) begin
                            run_d = run_inc;
                            if (run_inc == 4'(LOCK_CNT)) begin
                                state_d = LOCKED;
                            end
                        end else begin
                            run_d = 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (value != expect_q) begin
                            seq_err_d = 1'b1;
                            err_inc   = 1'b1;
                            run_d     = 4'd0;
                            state_d   = TRACK;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        run_d   = 4'd0;
                    end
                endcase
            end
        end
    end

    assign locked = (state_q == LOCKED);

endmodule
